// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback sequencing with memory timeout.
// Optional SIMPRISC_ILLEGAL_TRAP_EN: illegal opcodes trap instead of executing as a NOP.
module rv32i_mc_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic [31:0] ir,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halt,
    output logic        bus_err,
    output logic        trap,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        taken_q, taken_d;
    logic        halt_q, halt_d;
    logic        bus_err_q, bus_err_d;

    logic [6:0] opc;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_opimm, is_op, is_system, writes_rd;
    logic [7:0] cnt_inc;

    assign opc       = ir_q[6:0];
    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_jal    = (opc == 7'b1101111);
    assign is_jalr   = (opc == 7'b1100111);
    assign is_branch = (opc == 7'b1100011);
    assign is_load   = (opc == 7'b0000011);
    assign is_store  = (opc == 7'b0100011);
    assign is_opimm  = (opc == 7'b0010011);
    assign is_op     = (opc == 7'b0110011);
    assign is_system = (opc == 7'b1110011);
    assign writes_rd = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op;
    assign cnt_inc   = cnt_q + 8'd1;

`ifdef SIMPRISC_ILLEGAL_TRAP_EN
    logic is_legal;
    logic trap_q, trap_d;
    assign is_legal = writes_rd | is_branch | is_store | is_system | (opc == 7'b0001111);
    assign trap     = trap_q;
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        taken_d   = taken_q;
        halt_d    = halt_q;
        bus_err_d = bus_err_q;
`ifdef SIMPRISC_ILLEGAL_TRAP_EN
        trap_d    = trap_q;
`endif
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        wb_sel    = 2'd0;
        pc_sel    = 2'd0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                cnt_d   = 8'd0;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    bus_err_d = 1'b1;
                    halt_d    = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DECODE: begin
                if (is_system) begin
                    halt_d  = 1'b1;
                    state_d = S_HALT;
`ifdef SIMPRISC_ILLEGAL_TRAP_EN
                end else if (!is_legal) begin
                    trap_d  = 1'b1;
                    state_d = S_TRAP;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d = branch_taken;
                if (is_load || is_store) begin
                    cnt_d   = 8'd0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (cnt_inc == TIMEOUT_C) begin
                    bus_err_d = 1'b1;
                    halt_d    = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = writes_rd && (ir_q[11:7] != 5'd0);
                if (is_lui)                wb_sel = 2'd3;
                else if (is_jal | is_jalr) wb_sel = 2'd2;
                else if (is_load)          wb_sel = 2'd1;
                if (is_jal || (is_branch && taken_q)) pc_sel = 2'd1;
                else if (is_jalr)                     pc_sel = 2'd2;
                cnt_d   = 8'd0;
                state_d = S_FETCH;
            end
            default: state_d = state_q;  // HALT and TRAP hold until reset
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'd0;
            cnt_q     <= 8'd0;
            taken_q   <= 1'b0;
            halt_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            taken_q   <= taken_d;
            halt_q    <= halt_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef SIMPRISC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= trap_d;
    end
`endif

    assign ir      = ir_q;
    assign halt    = halt_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Directed bench for rv32i_mc_ctrl: per-opcode vector table plus wait, timeout, halt, illegal and reset sequences.
module tb_rv32i_mc_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_ack;
    logic        branch_taken;
    logic        imem_req;
    logic [31:0] ir;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halt;
    logic        bus_err;
    logic        trap;
    logic [2:0]  state;

    int n_checks = 0;
    int n_err    = 0;

    rv32i_mc_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_ack(dmem_ack), .branch_taken(branch_taken), .imem_req(imem_req),
        .ir(ir), .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .halt(halt),
        .bus_err(bus_err), .trap(trap), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        taken;
        logic        mem;
        logic        we;
        logic        rf;
        logic [1:0]  wb;
        logic [1:0]  pc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        imem_ack = 1'b0; dmem_ack = 1'b1; branch_taken = v.taken;
        do_reset();
        chk({tag, " reset state"}, 32'(state), 32'd0);
        imem_rdata = v.instr;
        imem_ack   = 1'b1;
        step();
        chk({tag, " fetch state"}, 32'(state), 32'd1);
        chk({tag, " imem_req"}, 32'(imem_req), 32'd1);
        step();
        chk({tag, " decode state"}, 32'(state), 32'd2);
        chk({tag, " ir"}, ir, v.instr);
        step();
        chk({tag, " exec state"}, 32'(state), 32'd3);
        chk({tag, " exec pc_we"}, 32'(pc_we), 32'd0);
        if (v.mem) begin
            step();
            chk({tag, " mem state"}, 32'(state), 32'd4);
            chk({tag, " dmem_req"}, 32'(dmem_req), 32'd1);
            chk({tag, " dmem_we"}, 32'(dmem_we), 32'(v.we));
        end
        step();
        chk({tag, " wb state"}, 32'(state), 32'd5);
        chk({tag, " wb pc_we"}, 32'(pc_we), 32'd1);
        chk({tag, " wb rf_we"}, 32'(rf_we), 32'(v.rf));
        chk({tag, " wb wb_sel"}, 32'(wb_sel), 32'(v.wb));
        chk({tag, " wb pc_sel"}, 32'(pc_sel), 32'(v.pc));
        chk({tag, " wb dmem_req"}, 32'(dmem_req), 32'd0);
        step();
        chk({tag, " next fetch"}, 32'(state), 32'd1);
        chk({tag, " post-wb pc_we"}, 32'(pc_we), 32'd0);
    endtask

    initial begin
        int cnt;
        int pulses;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; dmem_ack = 1'b0; branch_taken = 1'b0;

        //            instr          tk    mem   we    rf    wb     pc
        vecs[0]  = '{32'h00500093, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // addi x1,x0,5
        vecs[1]  = '{32'h00001137, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0}; // lui x2
        vecs[2]  = '{32'h00001037, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0}; // lui x0
        vecs[3]  = '{32'h00000197, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // auipc x3
        vecs[4]  = '{32'h000000EF, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1}; // jal x1
        vecs[5]  = '{32'h00008067, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2}; // jalr x0,0(x1)
        vecs[6]  = '{32'h00000463, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1}; // beq taken
        vecs[7]  = '{32'h00000463, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}; // beq not taken
        vecs[8]  = '{32'h0000A103, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0}; // lw x2
        vecs[9]  = '{32'h00112023, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0}; // sw x1,0(x2)
        vecs[10] = '{32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}; // addi x0 (nop)
        vecs[11] = '{32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // add x3
        vecs[12] = '{32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}; // fence
        vecs[13] = '{32'h00000493, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // addi x9, taken ignored

        for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

        // LW with dmem_ack withheld for 3 MEM cycles
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0;
        do_reset();
        imem_rdata = 32'h0000A103; imem_ack = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (state == 3'd4) begin
                cnt++;
                chk("lw wait dmem_we", 32'(dmem_we), 32'd0);
                if (cnt == 4) dmem_ack = 1'b1;
            end
            if (state == 3'd5) break;
        end
        chk("lw wait mem cycles", 32'(cnt), 32'd4);
        chk("lw wait wb state", 32'(state), 32'd5);
        chk("lw wait rf_we", 32'(rf_we), 32'd1);
        chk("lw wait wb_sel", 32'(wb_sel), 32'd1);
        chk("lw wait bus_err", 32'(bus_err), 32'd0);

        // Fetch timeout with TIMEOUT=4
        imem_ack = 1'b0; dmem_ack = 1'b0;
        do_reset();
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (state == 3'd1) cnt++;
            else if (state != 3'd0) break;
        end
        chk("timeout fetch cycles", 32'(cnt), 32'd4);
        chk("timeout state", 32'(state), 32'd6);
        chk("timeout bus_err", 32'(bus_err), 32'd1);
        chk("timeout halt", 32'(halt), 32'd1);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("halted imem_req", 32'(imem_req), 32'd0);
            chk("halted state", 32'(state), 32'd6);
        end
        do_reset();
        chk("reset clears bus_err", 32'(bus_err), 32'd0);
        chk("reset clears halt", 32'(halt), 32'd0);
        chk("reset clears ir", ir, 32'd0);

        // ECALL halts without a writeback
        imem_rdata = 32'h00000073; imem_ack = 1'b1;
        step(); step(); step();
        chk("ecall state", 32'(state), 32'd6);
        chk("ecall halt", 32'(halt), 32'd1);
        chk("ecall bus_err", 32'(bus_err), 32'd0);
        step();
        chk("ecall absorbing", 32'(state), 32'd6);
        chk("ecall pc_we", 32'(pc_we), 32'd0);

        // Illegal opcode
        imem_ack = 1'b0;
        do_reset();
        imem_rdata = 32'h0000007F; imem_ack = 1'b1;
        pulses = 0;
`ifdef SIMPRISC_ILLEGAL_TRAP_EN
        for (int c = 0; c < 6; c++) begin
            step();
            if (pc_we) pulses++;
        end
        chk("illegal state", 32'(state), 32'd7);
        chk("illegal trap", 32'(trap), 32'd1);
        chk("illegal pc_we pulses", 32'(pulses), 32'd0);
`else
        for (int c = 0; c < 5; c++) begin
            step();
            if (pc_we) begin
                pulses++;
                chk("illegal nop rf_we", 32'(rf_we), 32'd0);
                chk("illegal nop pc_sel", 32'(pc_sel), 32'd0);
            end
        end
        chk("illegal nop back to fetch", 32'(state), 32'd1);
        chk("illegal nop pc_we pulses", 32'(pulses), 32'd1);
        chk("illegal nop trap", 32'(trap), 32'd0);
`endif

        // Reset during MEM wait with a simultaneous dmem_ack
        imem_ack = 1'b0; dmem_ack = 1'b0;
        do_reset();
        imem_rdata = 32'h00112023; imem_ack = 1'b1;
        step(); step(); step(); step();
        chk("pre-reset mem state", 32'(state), 32'd4);
        chk("pre-reset dmem_we", 32'(dmem_we), 32'd1);
        rst = 1'b1; dmem_ack = 1'b1;
        step();
        rst = 1'b0; imem_ack = 1'b0;
        chk("mid-mem reset state", 32'(state), 32'd0);
        chk("mid-mem reset dmem_req", 32'(dmem_req), 32'd0);
        chk("mid-mem reset dmem_we", 32'(dmem_we), 32'd0);
        chk("mid-mem reset pc_we", 32'(pc_we), 32'd0);
        chk("mid-mem reset rf_we", 32'(rf_we), 32'd0);
        chk("mid-mem reset sels", 32'({wb_sel, pc_sel}), 32'd0);
        chk("mid-mem reset ir", ir, 32'd0);
        chk("mid-mem reset flags", 32'({halt, bus_err, trap}), 32'd0);
        step();
        chk("after reset fetch", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
